// File: rtl/slt_arbiter_pkg.sv
// Shared types for the two-requester signed less-than arbiter.
// The requester id is a single bit because the arbiter serves exactly two ports.
package slt_arbiter_pkg;

    localparam int NREQ = 2;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/slt.sv
// Structural signed less-than: the sign of the (N+1)-bit difference a - b.
// Widening by one bit means the subtraction cannot overflow, even for opposite-sign extremes.
module slt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N-1:0] b_inv;
    logic [N:0]   carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chain
            assign b_inv[gi]   = ~b[gi];
            assign carry[gi+1] = (a[gi] & b_inv[gi]) | (carry[gi] & (a[gi] ^ b_inv[gi]));
        end
    endgenerate

    // Bit N of sign_ext(a) + sign_ext(~b) + 1; the sum bits below it are never needed.
    assign lt = a[N-1] ^ b_inv[N-1] ^ carry[N];

endmodule

// File: rtl/slt_arbiter.sv
// Round-robin arbiter that serves two requesters through one shared signed comparator.
// Each transaction walks IDLE -> CMP -> RESP and holds RESP until its requester consumes the result.
module slt_arbiter
    import slt_arbiter_pkg::*;
#(
    parameter int N    = 32,
    parameter int NREQ = slt_arbiter_pkg::NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [N-1:0]    req_a0,
    input  logic [N-1:0]    req_b0,
    input  logic [N-1:0]    req_a1,
    input  logic [N-1:0]    req_b1,
    output logic [NREQ-1:0] rsp_valid,
    input  logic [NREQ-1:0] rsp_ready,
    output logic            rsp_out,
    output logic            busy
);

    state_t          state_reg;
    req_id_t         id_reg;
    req_id_t         last_grant_reg;
    logic [N-1:0]    a_reg;
    logic [N-1:0]    b_reg;
    logic            result_reg;
    logic [NREQ-1:0] rsp_valid_reg;
    logic            busy_reg;

    logic            any_valid;
    logic            accept;
    req_id_t         grant_id;
    logic [NREQ-1:0] id_onehot;
    logic            slt_out;

    assign any_valid = |req_valid;

    // Requester 1 wins when it is alone, or when both contend and requester 1 was not granted last.
    assign grant_id = req_valid[1] & (~req_valid[0] | ~last_grant_reg);

    assign accept = (state_reg == S_IDLE) & any_valid & ~rst;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
            assign req_ready[gi] = accept & (grant_id == req_id_t'(gi));
            assign id_onehot[gi] = (id_reg == req_id_t'(gi));
        end
    endgenerate

    slt #(
        .N(N)
    ) u_slt (
        .a  (a_reg),
        .b  (b_reg),
        .lt (slt_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            id_reg         <= 1'b0;
            last_grant_reg <= 1'b1;
            a_reg          <= '0;
            b_reg          <= '0;
            result_reg     <= 1'b0;
            rsp_valid_reg  <= '0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        a_reg          <= grant_id ? req_a1 : req_a0;
                        b_reg          <= grant_id ? req_b1 : req_b0;
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        busy_reg       <= 1'b1;
                        state_reg      <= S_CMP;
                    end
                end
                S_CMP: begin
                    result_reg    <= slt_out;
                    rsp_valid_reg <= id_onehot;
                    state_reg     <= S_RESP;
                end
                S_RESP: begin
                    // Only the owning requester's ready bit can release the result.
                    if (rsp_ready[id_reg]) begin
                        rsp_valid_reg <= '0;
                        busy_reg      <= 1'b0;
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= '0;
                    busy_reg      <= 1'b0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_out   = result_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/slt_arbiter.md
SLT_ARBITER -- requirements
Module: slt_arbiter

Interface
REQ-001 Parameter N SHALL default to 32 and set the operand width in bits.
REQ-002 Parameter NREQ SHALL be fixed at 2 and set the number of requester ports.
REQ-003 Port clk SHALL be an input of width 1 and be the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst SHALL be an input of width 1 and be the reset, asynchronous and active-high.
REQ-005 Port req_valid SHALL be an input of width NREQ, with bit i meaning requester i presents an operand pair.
REQ-006 Port req_ready SHALL be an output of width NREQ, with bit i meaning requester i's pair is accepted this cycle.
REQ-007 Ports req_a0, req_b0, req_a1 and req_b1 SHALL be inputs of width N carrying the signed two's-complement operands of requesters 0 and 1.
REQ-008 Port rsp_valid SHALL be an output of width NREQ, with bit i meaning a result for requester i is presented.
REQ-009 Port rsp_ready SHALL be an input of width NREQ, with bit i meaning requester i consumes its result.
REQ-010 Port rsp_out SHALL be an output of width 1 carrying the result: 1 when a is less than b (signed).
REQ-011 Port busy SHALL be an output of width 1, high in any state other than S_IDLE.

Function
REQ-012 The FSM SHALL have exactly the states S_IDLE, S_CMP and S_RESP.
REQ-013 In S_IDLE, if any req_valid bit is high, the arbiter SHALL grant exactly one requester, assert only that requester's req_ready bit combinationally, latch its operands and id, and move to S_CMP.
REQ-014 req_ready SHALL be all-zero outside S_IDLE and all-zero in S_IDLE when no req_valid bit is high.
REQ-015 Arbitration SHALL be round-robin: when both req_valid bits are high, the requester not granted most recently SHALL win.
REQ-016 When only one req_valid bit is high, that requester SHALL be granted regardless of history.
REQ-017 The last_grant register SHALL update only on an accept.
REQ-018 In S_CMP, a single shared signed comparator instance SHALL evaluate the latched operands; its result SHALL be registered, and the FSM SHALL move to S_RESP.
REQ-019 In S_RESP, rsp_valid[id] SHALL be high, the other rsp_valid bit SHALL be low, and rsp_out SHALL hold the registered result stable.
REQ-020 S_RESP SHALL be held until rsp_ready[id] is high; rsp_ready on the non-granted bit SHALL be ignored.
REQ-021 On rsp_ready[id] high in S_RESP, the FSM SHALL return to S_IDLE; no new accept SHALL occur in that same cycle.
REQ-022 Latency SHALL be fixed: for an accept at cycle t, rsp_valid SHALL rise at t+2, and the minimum accept-to-accept spacing SHALL be 3 cycles.
REQ-023 The comparison SHALL be correct across the full signed range, including the opposite-sign extremes -2^(N-1) versus 2^(N-1)-1; no overflow error is permitted.
REQ-024 Operand changes on a port after accept SHALL NOT affect an in-flight result.
REQ-025 A req_valid that drops before being granted SHALL simply not be accepted; no error condition exists.

Reset
REQ-026 On rst high, the FSM SHALL enter S_IDLE immediately, independent of clk.
REQ-027 On rst high, rsp_valid, req_ready, rsp_out and busy SHALL all be 0.
REQ-028 On rst high, the latched operands and id SHALL be cleared to 0.
REQ-029 On rst high, last_grant SHALL be set to 1, so that requester 0 wins the first contention.
REQ-030 Reset asserted in S_CMP or S_RESP SHALL discard the in-flight result; no rsp_valid SHALL appear after reset deasserts until a new accept occurs.

Structure
REQ-031 Package slt_arbiter_pkg SHALL hold the state enum (S_IDLE, S_CMP, S_RESP), the requester-id typedef (1 bit) and the NREQ constant.
REQ-032 The comparator SHALL be the existing structural slt module, instantiated once with .N(N); no behavioural comparison operators are permitted in the datapath.
REQ-033 Arbitration SHALL be implemented inline; no additional sub-module SHALL be created.

Verification
REQ-034 Single request: req_valid=01, a0=-5, b0=3 -> req_ready=01 at t, rsp_valid=01 at t+2, rsp_out=1.
REQ-035 Contention after reset: req_valid=11, a0=7, b0=7, a1=-2^31, b1=2^31-1 -> requester 0 served first with rsp_out=0; requester 1 served next with rsp_out=1.
REQ-036 Fairness: both requesters held valid for 6 grants -> grant order 0,1,0,1,0,1.
REQ-037 Backpressure: rsp_ready held 0 for 5 cycles in S_RESP, then 1 -> rsp_valid and rsp_out stable for all 5 cycles; S_IDLE on the cycle after the handshake.
REQ-038 Operand mutation: after accepting a1=2^31-1, b1=-1, change req_a1 to -8 in S_CMP -> rsp_out=0.
REQ-039 Reset mid-operation: assert rst in S_CMP -> outputs 0 immediately; no stale rsp_valid after release; the next contention is granted to requester 0.
